// File: rtl/fetch_pc_unit_if.sv
// Bundles the control-unit, instruction-memory and debug signals of fetch_pc_unit.
// upd_pc is a single-cycle request with no ready: it is accepted only while the unit is idle (fetch_busy low) and dropped otherwise.
interface fetch_pc_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            upd_pc;
    logic [2:0]      br_op;
    logic [31:0]     rs_val;
    logic [31:0]     imem_rdata;
    logic            imem_rd;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] pc_out;
    logic [31:0]     ir;
    logic [5:0]      opcode;
    logic [4:0]      func;
    logic [15:0]     imm16;
    logic            ir_valid;
    logic            fetch_busy;
    logic            fetch_fault;
    logic [2:0]      dbg_state;

    modport master (
        output upd_pc, br_op, rs_val, imem_rdata,
        input  imem_rd, imem_addr, pc_out, ir, opcode, func, imm16,
        input  ir_valid, fetch_busy, fetch_fault, dbg_state
    );

    modport slave (
        input  upd_pc, br_op, rs_val, imem_rdata,
        output imem_rd, imem_addr, pc_out, ir, opcode, func, imm16,
        output ir_valid, fetch_busy, fetch_fault, dbg_state
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage feeding the multicycle control unit.
// Optional PC bounds checking is enabled by defining PC_BOUNDS_CHECK_EN.
module fetch_pc_unit #(
    parameter int unsigned      PC_W       = 32,
    parameter int unsigned      IMEM_LAT   = 2,
    parameter logic [PC_W-1:0]  RESET_PC   = '0,
    parameter int unsigned      IMEM_DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_unit_if.slave bus
);
    localparam int unsigned CNT_W = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    localparam int unsigned EXT_W = (PC_W > 16) ? PC_W : 16;
    localparam logic [31:0] NOP   = 32'h9400_0000;

    if (IMEM_LAT < 1 || IMEM_DEPTH < 1) begin : g_bad_param
        $error("fetch_pc_unit: IMEM_LAT and IMEM_DEPTH must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3
`ifdef PC_BOUNDS_CHECK_EN
        , S_FAULT = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            rd_q, rd_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            taken;
    logic [EXT_W-1:0] imm_ext;
    logic [PC_W-1:0] next_pc;

    // Branch offset comes from the IR, which is stable while idle.
    assign imm_ext = EXT_W'($signed(ir_q[15:0]));

    always_comb begin
        taken = 1'b0;
        case (bus.br_op)
            3'b000:  taken = 1'b1;
            3'b001:  taken = bus.rs_val[31];
            3'b010:  taken = !bus.rs_val[31] && (bus.rs_val != 32'd0);
            3'b011:  taken = (bus.rs_val == 32'd0);
            default: taken = 1'b0;
        endcase
    end

    assign next_pc = taken ? (pc_q + imm_ext[PC_W-1:0]) : (pc_q + PC_W'(1));

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic [PC_W:0] DEPTH_LIM = (PC_W+1)'(IMEM_DEPTH);
    logic out_of_bounds;
    assign out_of_bounds = ({1'b0, next_pc} >= DEPTH_LIM);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.upd_pc) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
                    if (out_of_bounds) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_FETCH;
                        rd_d    = 1'b1;
                        addr_d  = next_pc;
                    end
`else
                    state_d = S_FETCH;
                    rd_d    = 1'b1;
                    addr_d  = next_pc;
`endif
                end
            end
            S_FETCH: begin
                // Out of reset the strobe is not yet up, so raise it here first.
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = pc_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(IMEM_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LATCH: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`ifdef PC_BOUNDS_CHECK_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            rd_q    <= 1'b0;
            addr_q  <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_rd    = rd_q;
    assign bus.imem_addr  = addr_q;
    assign bus.pc_out     = pc_q;
    assign bus.ir         = ir_q;
    assign bus.opcode     = ir_q[31:26];
    assign bus.func       = ir_q[4:0];
    assign bus.imm16      = ir_q[15:0];
    assign bus.ir_valid   = valid_q;
    assign bus.fetch_busy = busy_q;
    assign bus.dbg_state  = state_q;
`ifdef PC_BOUNDS_CHECK_EN
    assign bus.fetch_fault = (state_q == S_FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against an arithmetic PC model.
// Build with PC_BOUNDS_CHECK_EN defined to exercise the fault path.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
`ifdef PC_BOUNDS_CHECK_EN
    localparam int W = 12;
`else
    localparam int W = 10;
`endif
    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h9400_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_unit_if #(.PC_W(W)) bus ();

    fetch_pc_unit #(
        .PC_W(W), .IMEM_LAT(LAT), .RESET_PC(W'(0)), .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory: data is valid only on the edge LAT cycles after the read is sampled.
    logic [31:0] mem [0:4095];
    int          mem_cnt = 0;
    logic [W-1:0] mem_a;
    always @(posedge clk) begin
        if (bus.imem_rd) begin
            mem_a <= bus.imem_addr;
            if (LAT == 1) bus.imem_rdata <= mem[bus.imem_addr];
            else begin
                mem_cnt <= LAT - 1;
                bus.imem_rdata <= $urandom;
            end
        end else if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
            bus.imem_rdata <= (mem_cnt == 1) ? mem[mem_a] : $urandom;
        end else begin
            bus.imem_rdata <= $urandom;
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [W-1:0] m_pc;
    logic [31:0] m_ir;
    bit          m_faulted;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_next(logic [W-1:0] pc, logic [2:0] op,
                                                logic [31:0] rs, logic [15:0] imm);
        bit     tk;
        longint s;
        longint m;
        case (op)
            3'd0:    tk = 1'b1;
            3'd1:    tk = ($signed(rs) < 0);
            3'd2:    tk = ($signed(rs) > 0);
            3'd3:    tk = (rs == 0);
            default: tk = 1'b0;
        endcase
        s = tk ? longint'(pc) + longint'($signed(imm)) : longint'(pc) + 1;
        m = (longint'(1) << W) - 1;
        return W'(s & m);
    endfunction

    function automatic bit model_fault(logic [W-1:0] pc);
`ifdef PC_BOUNDS_CHECK_EN
        return int'(pc) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after the edge where the read strobe rises.
    task automatic wait_fetch(string tag, logic [W-1:0] pc, bit poke);
        int n;
        check({tag, "_rd"}, bus.imem_rd, 1);
        check({tag, "_addr"}, bus.imem_addr, pc);
        check({tag, "_pc"}, bus.pc_out, pc);
        check({tag, "_busy"}, bus.fetch_busy, 1);
        check({tag, "_valid0"}, bus.ir_valid, 0);
        n = 0;
        while (!bus.ir_valid && n < 20) begin
            if (poke && n == 1) begin
                bus.upd_pc = 1'b1;
                bus.br_op  = 3'd0;
            end else begin
                bus.upd_pc = 1'b0;
            end
            tick();
            n++;
            if (n == LAT + 1) check({tag, "_ir_edge"}, bus.ir, exp_q[0]);
        end
        bus.upd_pc = 1'b0;
        check({tag, "_latency"}, n, LAT + 2);
        m_ir = exp_q.pop_front();
        check({tag, "_ir"}, bus.ir, m_ir);
        check({tag, "_busy_end"}, bus.fetch_busy, 0);
        check({tag, "_pc_end"}, bus.pc_out, pc);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        bus.upd_pc = 1'b0;
        tick();
        check({tag, "_pc"}, bus.pc_out, 0);
        check({tag, "_ir"}, bus.ir, NOP);
        check({tag, "_valid"}, bus.ir_valid, 0);
        check({tag, "_busy"}, bus.fetch_busy, 1);
        check({tag, "_rd"}, bus.imem_rd, 0);
        check({tag, "_addr"}, bus.imem_addr, 0);
        check({tag, "_fault"}, bus.fetch_fault, 0);
        rst = 1'b0;
        m_pc = '0;
        m_faulted = 1'b0;
        tick();
        exp_q.push_back(mem[0]);
        wait_fetch({tag, "_fetch"}, '0, 1'b0);
    endtask

    // mode 0: plain, 1: stray upd_pc during fetch, 2: reset during WAIT
    task automatic do_upd(string tag, logic [2:0] op, logic [31:0] rs, int mode);
        logic [W-1:0] np;
        np = model_next(m_pc, op, rs, m_ir[15:0]);
        bus.br_op  = op;
        bus.rs_val = rs;
        bus.upd_pc = 1'b1;
        tick();
        bus.upd_pc = 1'b0;
        bus.br_op  = 3'($urandom);
        bus.rs_val = $urandom;
        m_pc = np;
        if (model_fault(np)) begin
            for (int i = 0; i < 3; i++) begin
                bus.upd_pc = (i == 1);
                check({tag, "_fault"}, bus.fetch_fault, 1);
                check({tag, "_fbusy"}, bus.fetch_busy, 1);
                check({tag, "_frd"}, bus.imem_rd, 0);
                check({tag, "_fpc"}, bus.pc_out, np);
                tick();
            end
            bus.upd_pc = 1'b0;
            m_faulted = 1'b1;
        end else if (mode == 2) begin
            tick();
            tick();
        end else begin
            exp_q.push_back(mem[np]);
            wait_fetch(tag, np, mode == 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0]  = 32'h0400_0005;
        mem[5]  = {16'h0800, 16'd5};
        mem[11] = {16'h0C00, 16'd9};
        mem[20] = {16'h1000, 16'hFFFC};
        mem[16] = {16'h1400, 16'd4};
        mem[21] = {16'h1800, 16'd2};
        bus.upd_pc = 1'b0;
        bus.br_op  = 3'd0;
        bus.rs_val = 32'd0;
        rst = 1'b1;
        tick();

        do_reset("reset");
        check("opcode", bus.opcode, 6'b000001);
        check("imm16", bus.imm16, 16'd5);
        check("func", bus.func, 5'd5);

        do_upd("br_a", 3'd0, $urandom, 0);
        do_upd("br_b", 3'd0, $urandom, 0);
        do_upd("nobr", 3'd4, $urandom, 0);
        do_upd("br_c", 3'd0, $urandom, 0);
        do_upd("bz_t", 3'd3, 32'd0, 0);
        do_upd("br_d", 3'd0, $urandom, 0);
        do_upd("bz_n", 3'd3, 32'd1, 1);
        do_upd("bmi_t", 3'd1, 32'h8000_0000, 0);
        do_upd("bpl_n", 3'd2, 32'd0, 0);
        check("pc_24", bus.pc_out, 24);

        do_upd("abort", 3'd0, $urandom, 2);
        mem[0] = 32'h0800_03FF;
        do_reset("midwait");

        do_upd("to_top", 3'd0, $urandom, 0);
        check("pc_1023", bus.pc_out, 1023);
        do_upd("edge", 3'd5, $urandom, 0);

        for (int k = 0; k < 24; k++) begin
            logic [31:0] rs;
            if (m_faulted) do_reset("rreset");
            case ($urandom_range(0, 2))
                0:       rs = 32'd0;
                1:       rs = {1'b0, 31'($urandom)} | 32'd1;
                default: rs = {1'b1, 31'($urandom)};
            endcase
            do_upd("rand", 3'($urandom_range(0, 7)), rs, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
